stream_flow_ctrl: RTL and testbench

Sequencing controller for the receive-to-transmit sample path. It sits between the input CDC FIFO, the per-sample DSP stage, the output FIFO and the interpolator, all on the system clock. It drives the shared DSP-stage enable, which is both the in-FIFO read strobe and the out-FIFO write strobe. It primes the output FIFO before releasing the interpolator, detects underrun and overrun, and on either fault runs a timed flush-and-restart sequence.

---
 rtl/stream_flow_ctrl.sv | 138 +++++++++++++
 tb/tb_stream_flow_ctrl.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/stream_flow_ctrl.sv
// stream_flow_ctrl
// Sequences the shared DSP-stage enable between the input CDC FIFO and the
// output FIFO, primes the output FIFO before releasing the interpolator, and
// runs a timed flush-and-restart whenever an underrun or overrun is seen.
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   S_IDLE  | waiting for the in-FIFO read side to leave reset
//   S_PRIME | filling the out-FIFO with PRIME_WORDS words, interp held off
//   S_RUN   | steady flow, interpolator enabled, faults monitored
//   S_FLUSH | flush asserted for FLUSH_CYCLES cycles, flags ignored
module stream_flow_ctrl #(
    parameter int unsigned PRIME_WORDS  = 16,
    parameter int unsigned FLUSH_CYCLES = 8,
    parameter int unsigned CNT_WIDTH    = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_rst_busy,
    input  logic                 in_almst_empty,
    input  logic                 in_full,
    input  logic                 out_almst_full,
    input  logic                 out_empty,
    input  logic                 interp_rd,
    output logic                 dsp_en,
    output logic                 interp_en,
    output logic                 flush,
    output logic [1:0]           state,
    output logic [CNT_WIDTH-1:0] underrun_cnt,
    output logic [CNT_WIDTH-1:0] overrun_cnt
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_PRIME = 2'd1,
        S_RUN   = 2'd2,
        S_FLUSH = 2'd3
    } state_t;

    localparam logic [7:0]           PRIME_LAST = 8'(PRIME_WORDS - 1);
    localparam logic [7:0]           FLUSH_LAST = 8'(FLUSH_CYCLES - 1);
    localparam logic [CNT_WIDTH-1:0] CNT_MAX    = '1;

    state_t     state_q;
    state_t     state_d;
    logic [7:0] prime_cnt;
    logic [7:0] flush_cnt;
    logic       xfer;
    logic       underrun;
    logic       overrun;
    logic       count_ur;
    logic       count_ov;

    assign state = state_q;

    // Next-state decode, fault qualification and the Mealy dsp_en strobe.
    always_comb begin
        state_d  = state_q;
        count_ur = 1'b0;
        count_ov = 1'b0;
        xfer     = !in_almst_empty && !out_almst_full;
        underrun = interp_rd && out_empty;
        overrun  = in_full;
        dsp_en   = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (!in_rst_busy) begin
                    state_d = S_PRIME;
                end
            end
            S_PRIME: begin
                dsp_en = xfer;
                // The interpolator is off while priming, so only overrun matters.
                if (overrun) begin
                    count_ov = 1'b1;
                    state_d  = S_FLUSH;
                end else if (dsp_en && (prime_cnt == PRIME_LAST)) begin
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                dsp_en = xfer;
                if (underrun || overrun) begin
                    count_ur = underrun;
                    count_ov = overrun;
                    state_d  = S_FLUSH;
                end
            end
            S_FLUSH: begin
                if (flush_cnt == FLUSH_LAST) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State, Moore outputs, sequencing timers and saturating fault counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            interp_en    <= 1'b0;
            flush        <= 1'b0;
            prime_cnt    <= '0;
            flush_cnt    <= '0;
            underrun_cnt <= '0;
            overrun_cnt  <= '0;
        end else begin
            state_q   <= state_d;
            interp_en <= (state_d == S_RUN);
            flush     <= (state_d == S_FLUSH);

            // Timers restart from zero on every entry into their state.
            if ((state_q == S_PRIME) && (state_d == S_PRIME)) begin
                if (dsp_en) begin
                    prime_cnt <= prime_cnt + 8'd1;
                end
            end else begin
                prime_cnt <= '0;
            end

            if ((state_q == S_FLUSH) && (state_d == S_FLUSH)) begin
                flush_cnt <= flush_cnt + 8'd1;
            end else begin
                flush_cnt <= '0;
            end

            if (count_ur && (underrun_cnt != CNT_MAX)) begin
                underrun_cnt <= underrun_cnt + 1'b1;
            end
            if (count_ov && (overrun_cnt != CNT_MAX)) begin
                overrun_cnt <= overrun_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_stream_flow_ctrl.sv
// Directed bench for stream_flow_ctrl. A second instance with 2-bit counters
// shares all inputs so counter saturation can be observed alongside the
// default build. Expected counter values are queued when a fault is driven
// and popped when the DUT enters flush.
module tb_stream_flow_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_rst_busy;
    logic        in_almst_empty;
    logic        in_full;
    logic        out_almst_full;
    logic        out_empty;
    logic        interp_rd;
    logic        dsp_en;
    logic        interp_en;
    logic        flush;
    logic [1:0]  state;
    logic [15:0] underrun_cnt;
    logic [15:0] overrun_cnt;

    logic        sat_dsp_en;
    logic        sat_interp_en;
    logic        sat_flush;
    logic [1:0]  sat_state;
    logic [1:0]  sat_ur;
    logic [1:0]  sat_ov;

    typedef struct {
        int ur;
        int ov;
        int ur2;
        int ov2;
    } exp_t;

    exp_t sb[$];
    int   vectors     = 0;
    int   miscompares = 0;
    int   m_ur = 0, m_ov = 0, m_ur2 = 0, m_ov2 = 0;
    int   n;
    int   k;

    always #5 clk = ~clk;

    stream_flow_ctrl #(.PRIME_WORDS(16), .FLUSH_CYCLES(8), .CNT_WIDTH(16)) dut (
        .clk(clk), .rst(rst), .in_rst_busy(in_rst_busy),
        .in_almst_empty(in_almst_empty), .in_full(in_full),
        .out_almst_full(out_almst_full), .out_empty(out_empty),
        .interp_rd(interp_rd), .dsp_en(dsp_en), .interp_en(interp_en),
        .flush(flush), .state(state),
        .underrun_cnt(underrun_cnt), .overrun_cnt(overrun_cnt)
    );

    stream_flow_ctrl #(.PRIME_WORDS(16), .FLUSH_CYCLES(8), .CNT_WIDTH(2)) dut_sat (
        .clk(clk), .rst(rst), .in_rst_busy(in_rst_busy),
        .in_almst_empty(in_almst_empty), .in_full(in_full),
        .out_almst_full(out_almst_full), .out_empty(out_empty),
        .interp_rd(interp_rd), .dsp_en(sat_dsp_en), .interp_en(sat_interp_en),
        .flush(sat_flush), .state(sat_state),
        .underrun_cnt(sat_ur), .overrun_cnt(sat_ov)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic wait_state(input logic [1:0] s, input int budget, input string tag);
        int i = 0;
        while (state !== s && i < budget) begin
            tick();
            i++;
        end
        chk(tag, 32'(state), 32'(s));
    endtask

    // Updates the reference counters for a driven fault and queues them.
    task automatic push_fault(input bit ur, input bit ov);
        exp_t e;
        if (ur) begin
            m_ur++;
            if (m_ur2 != 3) m_ur2++;
        end
        if (ov) begin
            m_ov++;
            if (m_ov2 != 3) m_ov2++;
        end
        e.ur = m_ur; e.ov = m_ov; e.ur2 = m_ur2; e.ov2 = m_ov2;
        sb.push_back(e);
    endtask

    task automatic check_sb(input string tag);
        exp_t e;
        if (sb.size() == 0) begin
            chk({tag, "_sb_empty"}, 32'd0, 32'd1);
        end else begin
            e = sb.pop_front();
            chk({tag, "_ur"},     32'(underrun_cnt), e.ur);
            chk({tag, "_ov"},     32'(overrun_cnt),  e.ov);
            chk({tag, "_sat_ur"}, 32'(sat_ur),       e.ur2);
            chk({tag, "_sat_ov"}, 32'(sat_ov),       e.ov2);
        end
    endtask

    // Counts consecutive flush cycles from the current one; optionally pulses
    // in_full mid-flush, which must be ignored.
    task automatic count_flush(input bit poke, output int cycles);
        cycles = 0;
        while (flush === 1'b1 && cycles < 50) begin
            if (dsp_en !== 1'b0 || interp_en !== 1'b0) begin
                chk("flush_outputs_quiet", {30'd0, dsp_en, interp_en}, 32'd0);
            end
            cycles++;
            in_full = poke && (cycles == 3);
            tick();
        end
        in_full = 1'b0;
    endtask

    initial begin
        rst = 1'b1; in_rst_busy = 1'b1; in_almst_empty = 1'b0; in_full = 1'b0;
        out_almst_full = 1'b0; out_empty = 1'b0; interp_rd = 1'b0;
        repeat (2) @(posedge clk);
        tick();
        chk("rst_state", 32'(state), 0);
        chk("rst_interp_en", 32'(interp_en), 0);
        chk("rst_flush", 32'(flush), 0);
        chk("rst_dsp_en", 32'(dsp_en), 0);
        chk("rst_ur", 32'(underrun_cnt), 0);
        chk("rst_ov", 32'(overrun_cnt), 0);

        // Reset release, in_rst_busy still high holds S_IDLE.
        rst = 1'b0;
        tick();
        chk("idle_busy_hold", 32'(state), 0);
        in_rst_busy = 1'b0;
        tick();
        chk("idle_to_prime", 32'(state), 1);
        chk("prime_interp_off", 32'(interp_en), 0);

        n = 0; k = 0;
        while (state === 2'd1 && k < 100) begin
            if (dsp_en === 1'b1) n++;
            k++;
            tick();
        end
        chk("prime_words", n, 16);
        chk("run_state", 32'(state), 2);
        chk("run_interp_en", 32'(interp_en), 1);
        chk("run_dsp_en", 32'(dsp_en), 1);

        // Back-pressure: 5 cycles out_almst_full then 3 cycles in_almst_empty.
        for (int i = 0; i < 8; i++) begin
            out_almst_full = (i < 5);
            in_almst_empty = (i >= 5);
            #1;
            chk("bp_dsp_en", 32'(dsp_en), 0);
            chk("bp_state", 32'(state), 2);
            tick();
        end
        out_almst_full = 1'b0; in_almst_empty = 1'b0;
        #1;
        chk("bp_release_dsp_en", 32'(dsp_en), 1);
        chk("bp_ur", 32'(underrun_cnt), 0);
        chk("bp_ov", 32'(overrun_cnt), 0);

        // Underrun; in_rst_busy rises during the flush to stretch S_IDLE.
        interp_rd = 1'b1; out_empty = 1'b1;
        push_fault(1'b1, 1'b0);
        tick();
        interp_rd = 1'b0; out_empty = 1'b0; in_rst_busy = 1'b1;
        chk("ur_state", 32'(state), 3);
        chk("ur_interp_en", 32'(interp_en), 0);
        #1;
        chk("ur_dsp_en", 32'(dsp_en), 0);
        check_sb("ur");
        count_flush(1'b1, n);
        chk("ur_flush_len", n, 8);
        chk("ur_then_idle", 32'(state), 0);
        chk("ur_flush_ignored_ov", 32'(overrun_cnt), 0);
        tick();
        chk("ur_idle_stretch", 32'(state), 0);
        in_rst_busy = 1'b0;
        tick();
        chk("ur_restart_prime", 32'(state), 1);
        wait_state(2'd2, 40, "ur_rerun");

        // Simultaneous underrun and overrun.
        in_full = 1'b1; interp_rd = 1'b1; out_empty = 1'b1;
        push_fault(1'b1, 1'b1);
        tick();
        in_full = 1'b0; interp_rd = 1'b0; out_empty = 1'b0;
        chk("both_state", 32'(state), 3);
        check_sb("both");
        count_flush(1'b0, n);
        chk("both_flush_len", n, 8);
        chk("both_then_idle", 32'(state), 0);
        tick();
        chk("both_earliest_prime", 32'(state), 1);

        // Overrun after 7 primed words.
        n = 0; k = 0;
        while (n < 7 && k < 50) begin
            if (dsp_en === 1'b1) n++;
            k++;
            tick();
        end
        chk("pov_still_prime", 32'(state), 1);
        in_full = 1'b1;
        push_fault(1'b0, 1'b1);
        tick();
        in_full = 1'b0;
        chk("pov_state", 32'(state), 3);
        chk("pov_interp_en", 32'(interp_en), 0);
        check_sb("pov");

        // Reset on the 4th flush cycle.
        repeat (3) tick();
        chk("midflush_flush", 32'(flush), 1);
        rst = 1'b1;
        tick();
        chk("midrst_state", 32'(state), 0);
        chk("midrst_flush", 32'(flush), 0);
        chk("midrst_interp_en", 32'(interp_en), 0);
        chk("midrst_dsp_en", 32'(dsp_en), 0);
        chk("midrst_ur", 32'(underrun_cnt), 0);
        chk("midrst_ov", 32'(overrun_cnt), 0);
        chk("midrst_sat_ur", 32'(sat_ur), 0);
        rst = 1'b0;
        m_ur = 0; m_ov = 0; m_ur2 = 0; m_ov2 = 0;

        // Five underruns: the 2-bit counter sticks at 3.
        wait_state(2'd2, 60, "sat_first_run");
        for (int i = 0; i < 5; i++) begin
            interp_rd = 1'b1; out_empty = 1'b1;
            push_fault(1'b1, 1'b0);
            tick();
            interp_rd = 1'b0; out_empty = 1'b0;
            check_sb("sat");
            count_flush(1'b0, n);
            chk("sat_flush_len", n, 8);
            wait_state(2'd2, 60, "sat_rerun");
        end
        chk("sat_hold", 32'(sat_ur), 3);
        chk("sat_wide_ur", 32'(underrun_cnt), 5);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
